// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared machine constants, ROB packet and retire FSM state types
package sys_defs;

  localparam int N_WAY       = 3;
  localparam int ARCH_REGS_G = 32;
  localparam int PHYS_REGS_G = 64;
  localparam int PHYS_IDX_W  = $clog2(PHYS_REGS_G);
  localparam int ARCH_IDX_W  = $clog2(ARCH_REGS_G);

  typedef logic [PHYS_IDX_W-1:0] PHYS_REG_IDX;
  typedef logic [ARCH_IDX_W-1:0] ARCH_REG_IDX;

  typedef struct packed {
    PHYS_REG_IDX t_new;
    PHYS_REG_IDX t_old;
    ARCH_REG_IDX arch_reg;
    logic        halt;
    logic        illegal;
    logic [31:0] npc;
  } ROB_PACKET;

  typedef enum logic {
    RETIRE_RUNNING = 1'b0,
    RETIRE_HALTED  = 1'b1
  } retire_state_e;

endpackage

// File: rtl/retire_stage_select.sv
// rtl/retire_stage_select.sv - prefix scanner: longest run of valid+complete head slots,
// closed after the first halt/illegal slot.
module retire_select #(
  parameter int N           = 3,
  parameter int SCALAR_BITS = 2
) (
  input  logic [N-1:0]           valid,
  input  logic [N-1:0]           complete,
  input  logic [N-1:0]           stop,
  output logic [N-1:0]           retire_mask,
  output logic [SCALAR_BITS-1:0] retire_count
);

  logic scan_open;

  always_comb begin
    retire_mask  = '0;
    retire_count = '0;
    scan_open    = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (scan_open && valid[i] && complete[i]) begin
        retire_mask[i] = 1'b1;
        retire_count   = retire_count + SCALAR_BITS'(1);
        scan_open      = !stop[i];
      end else begin
        scan_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order ROB commit: frees old tags, keeps the retirement map, halts on halt/illegal.
// Optional RETIRE_PERF_EN adds perf_cycles / perf_retired counters.
module retire_stage
  import sys_defs::*;
#(
  parameter int N           = N_WAY,
  parameter int ARCH_REGS   = ARCH_REGS_G,
  parameter int PHYS_REGS   = PHYS_REGS_G,
  parameter int SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  ROB_PACKET [N-1:0]                      rob_head,
  input  logic [N-1:0]                           rob_head_valid,
  input  logic [PHYS_REGS-1:0]                   complete_list,
  output logic [SCALAR_BITS-1:0]                 num_retiring,
  output logic [N-1:0][PHYS_IDX_W-1:0]           freed_regs,
  output logic [N-1:0]                           freed_valid,
  output logic [ARCH_REGS-1:0][PHYS_IDX_W-1:0]   arch_map,
  output logic                                   halted,
  output logic                                   illegal_stop
`ifdef RETIRE_PERF_EN
  ,output logic [63:0]                           perf_cycles
  ,output logic [63:0]                           perf_retired
`endif
);

  retire_state_e                       state_q, state_d;
  logic                                illegal_stop_q, illegal_stop_d;
  logic [ARCH_REGS-1:0][PHYS_IDX_W-1:0] arch_map_q, arch_map_d;

  logic [N-1:0]           slot_complete, slot_halt, slot_illegal, slot_stop;
  logic [N-1:0]           select_mask, retire_mask;
  logic [SCALAR_BITS-1:0] select_count;
  logic                   running, stop_now, stop_illegal;
  logic                   unused_npc;

  always_comb begin
    unused_npc = 1'b0;
    for (int i = 0; i < N; i++) begin
      slot_complete[i] = complete_list[rob_head[i].t_new];
      slot_halt[i]     = rob_head[i].halt;
      slot_illegal[i]  = rob_head[i].illegal;
      unused_npc       = unused_npc ^ (^rob_head[i].npc);
    end
    slot_stop = slot_halt | slot_illegal;
  end

  retire_select #(
    .N           (N),
    .SCALAR_BITS (SCALAR_BITS)
  ) u_select (
    .valid        (rob_head_valid),
    .complete     (slot_complete),
    .stop         (slot_stop),
    .retire_mask  (select_mask),
    .retire_count (select_count)
  );

  assign running      = (state_q == RETIRE_RUNNING);
  assign retire_mask  = running ? select_mask : '0;
  assign stop_now     = |(retire_mask & slot_stop);
  assign stop_illegal = |(retire_mask & slot_illegal);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RETIRE_RUNNING;
      illegal_stop_q <= 1'b0;
      for (int a = 0; a < ARCH_REGS; a++) begin
        arch_map_q[a] <= PHYS_IDX_W'(a);
      end
    end else begin
      state_q        <= state_d;
      illegal_stop_q <= illegal_stop_d;
      arch_map_q     <= arch_map_d;
    end
  end

  // Next state: HALTED is terminal until reset
  always_comb begin
    state_d        = state_q;
    illegal_stop_d = illegal_stop_q;
    case (state_q)
      RETIRE_RUNNING: begin
        if (stop_now) begin
          state_d        = RETIRE_HALTED;
          illegal_stop_d = stop_illegal;
        end
      end
      RETIRE_HALTED: state_d = RETIRE_HALTED;
      default:       state_d = RETIRE_RUNNING;
    endcase
  end

  // Later slots overwrite earlier ones so the youngest writer of an arch reg wins
  always_comb begin
    arch_map_d = arch_map_q;
    for (int i = 0; i < N; i++) begin
      if (retire_mask[i] && (rob_head[i].t_old != rob_head[i].t_new) &&
          (rob_head[i].arch_reg != '0)) begin
        arch_map_d[rob_head[i].arch_reg] = rob_head[i].t_new;
      end
    end
  end

  // Outputs
  always_comb begin
    halted       = (state_q == RETIRE_HALTED);
    illegal_stop = illegal_stop_q;
    arch_map     = arch_map_q;
    num_retiring = running ? select_count : '0;
    freed_valid  = retire_mask;
    for (int i = 0; i < N; i++) begin
      freed_regs[i] = '0;
      if (retire_mask[i]) begin
        freed_regs[i] = (rob_head[i].t_old == rob_head[i].t_new) ? rob_head[i].t_new
                                                                 : rob_head[i].t_old;
      end
    end
  end

`ifdef RETIRE_PERF_EN
  logic [63:0] perf_cycles_q, perf_cycles_d;
  logic [63:0] perf_retired_q, perf_retired_d;

  always_comb begin
    perf_cycles_d  = running ? perf_cycles_q + 64'd1 : perf_cycles_q;
    perf_retired_d = perf_retired_q + 64'(num_retiring);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order commit stage at the head of the ROB, consuming the ROB packets that dispatch allocates. Each cycle it retires the longest prefix of up to N completed head entries. It releases each retired entry's old physical register to the free list and maintains the architectural (retirement) map table. It stops the machine on a halt or illegal instruction through a small state machine.

## Interface
Parameters:
- N, default 3: superscalar width, equal to the dispatch width.
- ARCH_REGS, default 32: number of architectural registers.
- PHYS_REGS, default 64: number of physical registers.
- SCALAR_BITS, default $clog2(N+1): width of count ports.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rob_head  in  N x ROB_PACKET  ROB entries head..head+N-1 (T_new, T_old, Arch_reg, halt, illegal, NPC); index 0 is oldest.
- rob_head_valid  in  N  slot occupied; thermometer-coded from index 0.
- complete_list  in  PHYS_REGS  registered completion bits.
- num_retiring  out  SCALAR_BITS  entries popped from the ROB this cycle.
- freed_regs  out  N x PHYS_REG_IDX  registers returned to the free list.
- freed_valid  out  N  per-slot free enable.
- arch_map  out  ARCH_REGS x PHYS_REG_IDX  registered retirement map table, used for full recovery.
- halted  out  1  machine stopped (registered).
- illegal_stop  out  1  the stop was caused by an illegal instruction (registered).

## Operation
- Slot i is retirable when all four hold:
  - rob_head_valid[i] is set.
  - complete_list[rob_head[i].T_new] is set.
  - All slots below i are retirable.
  - No slot below i has halt or illegal set.
- A halt or illegal slot itself retires; it truncates the group after it.
- num_retiring = count of retirable slots; forced to 0 in state HALTED.
- Freeing, for each retirable slot i:
  - freed_valid[i] = 1.
  - freed_regs[i] = T_old.
  - When T_old == T_new (no destination), freed_regs[i] = T_new.
- Map update: for a retirable slot with T_old != T_new, next arch_map[Arch_reg] = T_new.
  - Slots are applied oldest to youngest, so the youngest write to the same Arch_reg wins.
  - Arch_reg 0 is never written.
- Non-retiring slots drive freed_valid = 0 and freed_regs = 0.
- FSM states:
  - RUNNING: retires normally. Moves to HALTED when any retiring slot has halt or illegal set.
  - HALTED: terminal. Retirement stays blocked until reset.
- In the HALTED transition, illegal_stop is set if the stopping slot has illegal set; halt and illegal in the same slot count as illegal.

## Timing
- num_retiring, freed_regs and freed_valid are combinational from the inputs and registered state, zero-latency, same cycle.
- The ROB pops, the free list frees and arch_map updates at the following edge.
- arch_map, halted and illegal_stop update at the edge after the triggering retirement.
- The halting instruction is counted in num_retiring during its own cycle.
- Reset values:
  - arch_map[i] = i.
  - State RUNNING.
  - halted = 0 and illegal_stop = 0.
  - Performance counters = 0.
  - Combinational outputs depend on inputs only; they read zero once rob_head_valid = 0.
- Reset mid-retirement discards all pending updates; reset has priority over every state transition.
- Full ROB: no special case.
- Empty ROB: all rob_head_valid = 0, so num_retiring = 0.
- A branch squash in the same cycle does not affect retirement; the ROB never squashes entries older than a branch.

## Configuration
- RETIRE_PERF_EN defined: adds two 64-bit outputs.
  - perf_cycles: counts every cycle in RUNNING.
  - perf_retired: accumulates num_retiring.
  - Both reset to 0 and freeze in HALTED.
- Undefined: both ports and their counters are absent; behaviour is otherwise identical.

## Structure
- ROB_PACKET, PHYS_REG_IDX, ARCH_REG_IDX and the retire FSM state enum live in sys_defs.
- ARCH_REGS, PHYS_REGS and N map to the existing global constants.
- Sub-module retire_select: a combinational prefix scanner that produces the retire mask and count from valid, complete, halt and illegal bits. The top level holds the FSM, arch_map and counters.

## Test plan
- Reset, then 3 completed entries (T_new 33/34/35, T_old 1/2/3, Arch 1/2/3) -> num_retiring = 3, freed = {1,2,3}; next cycle arch_map[1..3] = 33/34/35.
- Slot 1 not complete, slot 2 complete -> num_retiring = 1; only freed_valid[0] set.
- Slots 0 and 2 both write Arch 5 (T_new 40, then 42) -> arch_map[5] = 42; both T_olds freed.
- Halt in slot 1 with slot 2 complete -> num_retiring = 2; halted = 1 the next cycle; num_retiring = 0 afterwards despite valid complete heads.
- Illegal in slot 0 -> num_retiring = 1, illegal_stop = 1. Assert reset while HALTED -> RUNNING, arch_map identity.
- No-destination entry (T_old == T_new == 50) -> freed_regs = 50, arch_map unchanged.
- With RETIRE_PERF_EN: 10 cycles retiring 2 per cycle -> perf_retired = 20, perf_cycles = 10.
